// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator for the video controller. It walks a
// horizontal counter (hcnt) over HTOT pixel clocks per line and a vertical
// counter (vcnt) over VTOT lines per frame. From that position it produces
// sync, blanking and pixel coordinates toward video_if. It also produces a
// pixel-fetch request LOOKAHEAD cycles ahead of display for the frame-buffer
// reader.
//
// Line layout (vertical is identical, in lines):
//   [0, HFP)               front porch
//   [HFP, HFP+HPULSE)      sync pulse
//   [HFP+HPULSE, HBLK)     back porch
//   [HBLK, HTOT)           active video
//
// Ports
//   clk          in   1    pixel clock
//   nrst         in   1    asynchronous active-low reset
//   en           in   1    run enable; low holds the raster at the origin
//   HS           out  1    horizontal sync, active level HS_POL
//   VS           out  1    vertical sync, active level VS_POL
//   BLANK        out  1    1 = active pixel, 0 = blanking
//   pix_x        out  XW   active column, 0 outside the active area
//   pix_y        out  YW   active line, 0 outside the active area
//   line_start   out  1    pulse at hcnt==0
//   frame_start  out  1    pulse at hcnt==0 && vcnt==0
//   req_valid    out  1    fetch request for (req_x, req_y)
//   req_x        out  XW   column to fetch (0 when req_valid is low)
//   req_y        out  YW   line to fetch (0 when req_valid is low)
//   frame_cnt    out  16   completed frames, wraps silently
//
// Every output is a flop loaded from a decode of the *next* counter value.
// The outputs therefore describe the counter position held in the same cycle
// without any combinational path to the ports.
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOOKAHEAD = 2,
    localparam int XW       = $clog2(HDISP),
    localparam int YW       = $clog2(VDISP)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          en,
    output logic          HS,
    output logic          VS,
    output logic          BLANK,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          req_valid,
    output logic [XW-1:0] req_x,
    output logic [YW-1:0] req_y,
    output logic [15:0]   frame_cnt
);

    // -------------------------------------------------------------------------
    // Derived geometry
    // -------------------------------------------------------------------------
    localparam int HBLK = HFP + HPULSE + HBP;
    localparam int HTOT = HBLK + HDISP;
    localparam int VBLK = VFP + VPULSE + VBP;
    localparam int VTOT = VBLK + VDISP;

    // The horizontal counter is wide enough to also hold hcnt+LOOKAHEAD, so
    // the request window test never overflows.
    localparam int HW = $clog2(HTOT + LOOKAHEAD + 1);
    localparam int VW = $clog2(VTOT + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT      = HW'(HBLK);
    localparam logic [HW-1:0] H_TOT      = HW'(HTOT);
    localparam logic [HW-1:0] H_LA       = HW'(LOOKAHEAD);

    localparam logic [VW-1:0] V_LAST     = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT      = VW'(VBLK);

    localparam logic HS_IDLE = ~HS_POL;
    localparam logic VS_IDLE = ~VS_POL;

    // Elaboration-time guard on the request lead.
    video_timing_gen_param_chk #(
        .LOOKAHEAD (LOOKAHEAD),
        .HBLK      (HBLK)
    ) u_param_chk ();

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [HW-1:0] hcnt_r;
    logic [VW-1:0] vcnt_r;
    // run_r is low while idle. The first enabled edge then lands on the
    // origin instead of advancing past it.
    logic          run_r;

    logic [HW-1:0] hcnt_nxt_s;
    logic [VW-1:0] vcnt_nxt_s;
    logic          frame_wrap_s;

    logic [HW-1:0] h_la_s;
    logic          h_act_s;
    logic          v_act_s;
    logic          h_req_s;
    logic          hs_nxt_s;
    logic          vs_nxt_s;
    logic          blank_nxt_s;
    logic [XW-1:0] pix_x_nxt_s;
    logic [YW-1:0] pix_y_nxt_s;
    logic          line_start_nxt_s;
    logic          frame_start_nxt_s;
    logic          req_valid_nxt_s;
    logic [XW-1:0] req_x_nxt_s;
    logic [YW-1:0] req_y_nxt_s;

    // Next raster position: restart at origin after idle, else advance/wrap.
    always_comb begin
        hcnt_nxt_s   = {HW{1'b0}};
        vcnt_nxt_s   = {VW{1'b0}};
        frame_wrap_s = 1'b0;
        if (!run_r) begin
            hcnt_nxt_s = {HW{1'b0}};
            vcnt_nxt_s = {VW{1'b0}};
        end else if (hcnt_r == H_LAST) begin
            hcnt_nxt_s = {HW{1'b0}};
            if (vcnt_r == V_LAST) begin
                vcnt_nxt_s   = {VW{1'b0}};
                frame_wrap_s = 1'b1;
            end else begin
                vcnt_nxt_s = vcnt_r + {{(VW-1){1'b0}}, 1'b1};
            end
        end else begin
            hcnt_nxt_s = hcnt_r + {{(HW-1){1'b0}}, 1'b1};
            vcnt_nxt_s = vcnt_r;
        end
    end

    // Output decode of the next position, loaded into the output flops.
    always_comb begin
        h_la_s   = hcnt_nxt_s + H_LA;
        h_act_s  = (hcnt_nxt_s >= H_ACT);
        v_act_s  = (vcnt_nxt_s >= V_ACT);
        // Upper bound at HTOT keeps requests inside the current line.
        h_req_s  = (h_la_s >= H_ACT) && (h_la_s < H_TOT);

        if ((hcnt_nxt_s >= H_SYNC_BEG) && (hcnt_nxt_s < H_SYNC_END)) begin
            hs_nxt_s = HS_POL;
        end else begin
            hs_nxt_s = HS_IDLE;
        end

        if ((vcnt_nxt_s >= V_SYNC_BEG) && (vcnt_nxt_s < V_SYNC_END)) begin
            vs_nxt_s = VS_POL;
        end else begin
            vs_nxt_s = VS_IDLE;
        end

        blank_nxt_s = h_act_s && v_act_s;
        if (blank_nxt_s) begin
            pix_x_nxt_s = XW'(hcnt_nxt_s - H_ACT);
            pix_y_nxt_s = YW'(vcnt_nxt_s - V_ACT);
        end else begin
            pix_x_nxt_s = {XW{1'b0}};
            pix_y_nxt_s = {YW{1'b0}};
        end

        req_valid_nxt_s = h_req_s && v_act_s;
        if (req_valid_nxt_s) begin
            req_x_nxt_s = XW'(h_la_s - H_ACT);
            req_y_nxt_s = YW'(vcnt_nxt_s - V_ACT);
        end else begin
            req_x_nxt_s = {XW{1'b0}};
            req_y_nxt_s = {YW{1'b0}};
        end

        line_start_nxt_s  = (hcnt_nxt_s == {HW{1'b0}});
        frame_start_nxt_s = line_start_nxt_s && (vcnt_nxt_s == {VW{1'b0}});
    end

    // Raster counters, frame counter and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hcnt_r      <= {HW{1'b0}};
            vcnt_r      <= {VW{1'b0}};
            run_r       <= 1'b0;
            HS          <= HS_IDLE;
            VS          <= VS_IDLE;
            BLANK       <= 1'b0;
            pix_x       <= {XW{1'b0}};
            pix_y       <= {YW{1'b0}};
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            req_valid   <= 1'b0;
            req_x       <= {XW{1'b0}};
            req_y       <= {YW{1'b0}};
            frame_cnt   <= 16'd0;
        end else if (!en) begin
            // Idle: raster parked at origin, outputs quiet, frame_cnt kept.
            hcnt_r      <= {HW{1'b0}};
            vcnt_r      <= {VW{1'b0}};
            run_r       <= 1'b0;
            HS          <= HS_IDLE;
            VS          <= VS_IDLE;
            BLANK       <= 1'b0;
            pix_x       <= {XW{1'b0}};
            pix_y       <= {YW{1'b0}};
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            req_valid   <= 1'b0;
            req_x       <= {XW{1'b0}};
            req_y       <= {YW{1'b0}};
        end else begin
            hcnt_r      <= hcnt_nxt_s;
            vcnt_r      <= vcnt_nxt_s;
            run_r       <= 1'b1;
            HS          <= hs_nxt_s;
            VS          <= vs_nxt_s;
            BLANK       <= blank_nxt_s;
            pix_x       <= pix_x_nxt_s;
            pix_y       <= pix_y_nxt_s;
            line_start  <= line_start_nxt_s;
            frame_start <= frame_start_nxt_s;
            req_valid   <= req_valid_nxt_s;
            req_x       <= req_x_nxt_s;
            req_y       <= req_y_nxt_s;
            frame_cnt   <= frame_cnt + {15'd0, frame_wrap_s};
        end
    end

endmodule

// -----------------------------------------------------------------------------
// video_timing_gen_param_chk
//
// Elaboration-only check on the request lead. A request must not start more
// than one blanking interval early, or it would belong to the previous line.
// No ports.
// -----------------------------------------------------------------------------
module video_timing_gen_param_chk #(
    parameter int LOOKAHEAD = 0,
    parameter int HBLK      = 1
) ();

    if ((LOOKAHEAD < 0) || (LOOKAHEAD > HBLK - 1)) begin : g_bad_lookahead
        $error("video_timing_gen: LOOKAHEAD %0d outside 0..%0d", LOOKAHEAD, HBLK - 1);
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// Bench for video_timing_gen. Three instances share clk/nrst/en and differ
// only in LOOKAHEAD (4, 0, 23). The stimulus process drives en/nrst and
// advances a flat pixel-index model of the raster (position p within the
// frame, frame count). For each upcoming clock edge it queues the expected
// model state. A monitor on the falling edge pops that state and derives the
// expected outputs of each instance from h = p % HTOT and v = p / HTOT. It
// also pairs every request with the pixel shown LOOKAHEAD cycles later.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HDISP  = 160;
    localparam int VDISP  = 90;
    localparam int HFP    = 4;
    localparam int HPULSE = 8;
    localparam int HBP    = 12;
    localparam int VFP    = 1;
    localparam int VPULSE = 2;
    localparam int VBP    = 3;
    localparam int HBLK   = HFP + HPULSE + HBP;   // 24
    localparam int VBLK   = VFP + VPULSE + VBP;   // 6
    localparam int HTOT   = HBLK + HDISP;         // 184
    localparam int VTOT   = VBLK + VDISP;         // 96
    localparam int FRAME  = HTOT * VTOT;          // 17664
    localparam int NINST  = 3;

    typedef struct {
        int tgt;    // clock-edge index this expectation applies after
        bit run;
        int p;
        int fc;
        bit wrap;
    } exp_t;

    typedef struct {
        int x;
        int y;
        int due;
    } pend_t;

    logic clk;
    logic nrst;
    logic en;

    logic        hs_w [NINST];
    logic        vs_w [NINST];
    logic        bl_w [NINST];
    logic [7:0]  px_w [NINST];
    logic [6:0]  py_w [NINST];
    logic        ls_w [NINST];
    logic        fs_w [NINST];
    logic        rv_w [NINST];
    logic [7:0]  rx_w [NINST];
    logic [6:0]  ry_w [NINST];
    logic [15:0] fc_w [NINST];

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    exp_t  exp_q[$];
    pend_t pq[NINST][$];
    int    req_cnt   [NINST];
    int    blank_cnt [NINST];
    int    last_fs = -1;

    // model state
    bit m_run = 1'b0;
    int m_p   = 0;
    int m_fc  = 0;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        localparam int LA = (g == 0) ? 4 : ((g == 1) ? 0 : 23);
        video_timing_gen #(
            .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
            .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
            .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(LA)
        ) u_dut (
            .clk         (clk),
            .nrst        (nrst),
            .en          (en),
            .HS          (hs_w[g]),
            .VS          (vs_w[g]),
            .BLANK       (bl_w[g]),
            .pix_x       (px_w[g]),
            .pix_y       (py_w[g]),
            .line_start  (ls_w[g]),
            .frame_start (fs_w[g]),
            .req_valid   (rv_w[g]),
            .req_x       (rx_w[g]),
            .req_y       (ry_w[g]),
            .frame_cnt   (fc_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic int la_of(input int i);
        case (i)
            0:       return 4;
            1:       return 0;
            default: return 23;
        endcase
    endfunction

    // Expected output vector from the raster rules, for one model state.
    function automatic logic [51:0] exp_vec(input exp_t e, input int la);
        int h, v;
        logic hs, vs, bl, ls, fs, rv;
        logic [7:0] px, rx;
        logic [6:0] py, ry;
        if (!e.run) begin
            return {1'b1, 1'b1, 1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 16'(e.fc)};
        end
        h  = e.p % HTOT;
        v  = e.p / HTOT;
        hs = (h >= HFP && h < HFP + HPULSE) ? 1'b0 : 1'b1;
        vs = (v >= VFP && v < VFP + VPULSE) ? 1'b0 : 1'b1;
        bl = (h >= HBLK) && (v >= VBLK);
        px = bl ? 8'(h - HBLK) : 8'd0;
        py = bl ? 7'(v - VBLK) : 7'd0;
        ls = (h == 0);
        fs = (e.p == 0);
        rv = (h + la >= HBLK) && (h + la < HTOT) && (v >= VBLK);
        rx = rv ? 8'(h + la - HBLK) : 8'd0;
        ry = rv ? 7'(v - VBLK) : 7'd0;
        return {hs, vs, bl, px, py, ls, fs, rv, rx, ry, 16'(e.fc)};
    endfunction

    // Drive one cycle of stimulus and queue the model's expectation for it.
    task automatic step(input bit en_v, input bit rst_v);
        exp_t e;
        @(negedge clk);
        #1;
        en   = en_v;
        nrst = rst_v;
        e.wrap = 1'b0;
        if (!rst_v) begin
            m_run = 1'b0; m_p = 0; m_fc = 0;
        end else if (!en_v) begin
            m_run = 1'b0; m_p = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_p = 0;
        end else begin
            m_p++;
            if (m_p == FRAME) begin
                m_p    = 0;
                m_fc   = (m_fc + 1) % 65536;
                e.wrap = 1'b1;
            end
        end
        e.tgt = cyc + 1;
        e.run = m_run;
        e.p   = m_p;
        e.fc  = m_fc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the queued model state.
    always @(negedge clk) begin : mon
        exp_t e;
        pend_t pd;
        logic [51:0] act, want;
        while (exp_q.size() > 0 && exp_q[0].tgt < cyc) begin
            checks++; errors++;
            $display("FAIL stale_exp cyc %0d got expectation for edge %0d, required edge %0d",
                     cyc, exp_q[0].tgt, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
            e = exp_q.pop_front();
            if (e.run && e.p == 0) begin
                if (e.wrap) begin
                    for (int i = 0; i < NINST; i++) begin
                        checks++;
                        if (req_cnt[i] != HDISP * VDISP) begin
                            errors++;
                            $display("FAIL req_per_frame inst %0d got %0d required %0d", i, req_cnt[i], HDISP * VDISP);
                        end
                        checks++;
                        if (blank_cnt[i] != HDISP * VDISP) begin
                            errors++;
                            $display("FAIL blank_per_frame inst %0d got %0d required %0d", i, blank_cnt[i], HDISP * VDISP);
                        end
                    end
                    checks++;
                    if (cyc - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d required %0d", cyc - last_fs, FRAME);
                    end
                end
                for (int i = 0; i < NINST; i++) begin
                    req_cnt[i]   = 0;
                    blank_cnt[i] = 0;
                end
            end
            if (fs_w[0]) last_fs = cyc;
            for (int i = 0; i < NINST; i++) begin
                act  = {hs_w[i], vs_w[i], bl_w[i], px_w[i], py_w[i], ls_w[i], fs_w[i],
                        rv_w[i], rx_w[i], ry_w[i], fc_w[i]};
                want = exp_vec(e, la_of(i));
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL outputs inst %0d cyc %0d p %0d got %h required %h",
                             i, cyc, e.p, act, want);
                end
                if (!e.run) begin
                    pq[i].delete();
                end else begin
                    if (rv_w[i]) begin
                        req_cnt[i]++;
                        pd.x   = int'(rx_w[i]);
                        pd.y   = int'(ry_w[i]);
                        pd.due = cyc + la_of(i);
                        pq[i].push_back(pd);
                    end
                    if (bl_w[i]) begin
                        blank_cnt[i]++;
                        checks++;
                        if (pq[i].size() == 0) begin
                            errors++;
                            $display("FAIL req_match inst %0d cyc %0d got no request for pixel (%0d,%0d)",
                                     i, cyc, px_w[i], py_w[i]);
                        end else begin
                            pd = pq[i].pop_front();
                            if (pd.x != int'(px_w[i]) || pd.y != int'(py_w[i]) || pd.due != cyc) begin
                                errors++;
                                $display("FAIL req_match inst %0d cyc %0d got pixel (%0d,%0d) required req (%0d,%0d) due %0d",
                                         i, cyc, px_w[i], py_w[i], pd.x, pd.y, pd.due);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        nrst = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < NINST; i++) begin
            req_cnt[i]   = 0;
            blank_cnt[i] = 0;
        end

        // reset, then idle with reset released
        repeat (3) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);

        // two full frames plus a little
        repeat (2 * FRAME + 100) step(1'b1, 1'b1);

        // run to hcnt=100, vcnt=50, then drop enable for 10 cycles
        guard = 0;
        while (m_p != 50 * HTOT + 100 && guard < FRAME) begin
            step(1'b1, 1'b1);
            guard++;
        end
        repeat (10) step(1'b0, 1'b1);
        repeat (FRAME + 50) step(1'b1, 1'b1);

        // randomized enable drops and one mid-line reset
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(300, 50)) step(1'b1, 1'b1);
            if (k == 10) begin
                repeat (2) step(1'b1, 1'b0);
            end else begin
                repeat ($urandom_range(5, 1)) step(1'b0, 1'b1);
            end
        end
        repeat (5) step(1'b0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
